sram_oq_write_ctrl: RTL and testbench

- Memory-clock-domain stage directly downstream of the AXI-to-FIFO async bridge.
- Accepts the bridge's DATA_W-bit words tagged with a one-hot output-queue select (oq), and maps each word into that queue's circular region of the shared SRAM.
- Issues one SRAM write per accepted word and tracks per-queue occupancy, which a downstream reader releases.
- Throttles the bridge through output_enable.

---
 rtl/sram_oq_write_ctrl.sv | 119 +++++++++++
 tb/tb_sram_oq_write_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_oq_write_ctrl.sv
// Memory-domain write controller: maps one-hot-tagged bridge words into per-queue SRAM rings.
// Optional per-queue/drop statistics ports are enabled by defining SRAM_OQ_WR_STATS_EN.
module sram_oq_write_ctrl #(
  parameter int DATA_W   = 202,
  parameter int NUM_Q    = 5,
  parameter int QID_W    = 3,
  parameter int Q_ADDR_W = 10,
  parameter int OE_SLACK = 2
) (
  input  logic                            memclk,
  input  logic                            memreset,
  input  logic [DATA_W-1:0]               dout,
  input  logic                            dout_valid,
  input  logic [NUM_Q-1:0]                oq,
  output logic                            output_enable,
  output logic                            sram_wr_en,
  output logic [QID_W+Q_ADDR_W-1:0]       sram_wr_addr,
  output logic [DATA_W-1:0]               sram_wr_data,
  input  logic                            rd_release,
  input  logic [QID_W-1:0]                rd_release_q,
  output logic [NUM_Q*(Q_ADDR_W+1)-1:0]   q_count,
  output logic [NUM_Q-1:0]                q_full,
  output logic                            drop_pulse,
  output logic                            err_oq
`ifdef SRAM_OQ_WR_STATS_EN
  ,
  output logic [NUM_Q*32-1:0]             wr_word_cnt,
  output logic [31:0]                     drop_cnt
`endif
);

  localparam int CW = Q_ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH    = CW'(2 ** Q_ADDR_W);
  localparam logic [CW-1:0] OE_LIMIT = DEPTH - CW'(OE_SLACK);

  logic [Q_ADDR_W-1:0] wptr  [NUM_Q];
  logic [CW-1:0]       count [NUM_Q];

  logic                one_hot;
  logic                room;
  logic                accept;
  logic                bad;
  logic                drop;
  logic                oe_next;
  logic [QID_W-1:0]    sel_q;
  logic [Q_ADDR_W-1:0] sel_wptr;
  logic [NUM_Q-1:0]    inc;
  logic [NUM_Q-1:0]    dec;

  always_comb begin
    one_hot  = (oq != '0) && ((oq & (oq - NUM_Q'(1))) == '0);
    room     = 1'b0;
    sel_q    = '0;
    sel_wptr = '0;
    oe_next  = 1'b1;
    dec      = '0;
    q_count  = '0;
    q_full   = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      // Selection is only meaningful when oq is one-hot; accept gates it otherwise.
      if (oq[i]) begin
        room     = room | (count[i] < DEPTH);
        sel_q    = QID_W'(i);
        sel_wptr = wptr[i];
      end
      if (count[i] >= OE_LIMIT) oe_next = 1'b0;
      dec[i]               = rd_release && (rd_release_q == QID_W'(i)) && (count[i] != '0);
      q_count[i*CW +: CW]  = count[i];
      q_full[i]            = (count[i] == DEPTH);
    end
    accept = dout_valid && one_hot && room;
    bad    = dout_valid && !one_hot;
    drop   = dout_valid && !accept;
    inc    = accept ? oq : '0;
  end

  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        wptr[i]  <= '0;
        count[i] <= '0;
      end
      output_enable <= 1'b0;
      sram_wr_en    <= 1'b0;
      sram_wr_addr  <= '0;
      sram_wr_data  <= '0;
      drop_pulse    <= 1'b0;
      err_oq        <= 1'b0;
    end else begin
      output_enable <= oe_next;
      sram_wr_en    <= accept;
      drop_pulse    <= drop;
      if (bad) err_oq <= 1'b1;
      if (accept) begin
        sram_wr_addr <= {sel_q, sel_wptr};
        sram_wr_data <= dout;
      end
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        if (inc[i]) wptr[i] <= wptr[i] + Q_ADDR_W'(1);
        count[i] <= count[i] + CW'(inc[i]) - CW'(dec[i]);
      end
    end
  end

`ifdef SRAM_OQ_WR_STATS_EN
  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      wr_word_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        if (inc[i]) wr_word_cnt[i*32 +: 32] <= wr_word_cnt[i*32 +: 32] + 32'd1;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_oq_write_ctrl.sv
// Scoreboard bench for sram_oq_write_ctrl: directed scenarios followed by randomized traffic.
module tb_sram_oq_write_ctrl;
  localparam int DATA_W   = 202;
  localparam int NUM_Q    = 5;
  localparam int QID_W    = 3;
  localparam int Q_ADDR_W = 10;
  localparam int OE_SLACK = 2;
  localparam int CW       = Q_ADDR_W + 1;
  localparam int DEPTH    = 2 ** Q_ADDR_W;

  logic                          memclk;
  logic                          memreset;
  logic [DATA_W-1:0]             dout;
  logic                          dout_valid;
  logic [NUM_Q-1:0]              oq;
  logic                          output_enable;
  logic                          sram_wr_en;
  logic [QID_W+Q_ADDR_W-1:0]     sram_wr_addr;
  logic [DATA_W-1:0]             sram_wr_data;
  logic                          rd_release;
  logic [QID_W-1:0]              rd_release_q;
  logic [NUM_Q*CW-1:0]           q_count;
  logic [NUM_Q-1:0]              q_full;
  logic                          drop_pulse;
  logic                          err_oq;
`ifdef SRAM_OQ_WR_STATS_EN
  logic [NUM_Q*32-1:0]           wr_word_cnt;
  logic [31:0]                   drop_cnt;
`endif

  sram_oq_write_ctrl #(
    .DATA_W(DATA_W), .NUM_Q(NUM_Q), .QID_W(QID_W), .Q_ADDR_W(Q_ADDR_W), .OE_SLACK(OE_SLACK)
  ) dut (
    .memclk(memclk), .memreset(memreset), .dout(dout), .dout_valid(dout_valid), .oq(oq),
    .output_enable(output_enable), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .rd_release(rd_release), .rd_release_q(rd_release_q),
    .q_count(q_count), .q_full(q_full), .drop_pulse(drop_pulse), .err_oq(err_oq)
`ifdef SRAM_OQ_WR_STATS_EN
    , .wr_word_cnt(wr_word_cnt), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct packed {
    logic [QID_W+Q_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]         data;
  } wr_t;

  wr_t  wq[$];
  logic dq[$];
  int   checks = 0;
  int   errors = 0;

  int   m_cnt[NUM_Q];
  int   m_wp[NUM_Q];
  logic m_err;
  logic m_oe;

  initial memclk = 1'b0;
  always #5 memclk = ~memclk;

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) w = {w[DATA_W-33:0], 32'($urandom)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_Q; i++) begin
      m_cnt[i] = 0;
      m_wp[i]  = 0;
    end
    m_err = 1'b0;
    m_oe  = 1'b0;
  endtask

  task automatic check_state();
    logic [NUM_Q*CW-1:0] ec;
    logic [NUM_Q-1:0]    ef;
    for (int i = 0; i < NUM_Q; i++) begin
      ec[i*CW +: CW] = CW'(m_cnt[i]);
      ef[i]          = (m_cnt[i] == DEPTH);
    end
    chk("q_count", q_count, ec);
    chk("q_full", q_full, ef);
    chk("output_enable", output_enable, m_oe);
    chk("err_oq", err_oq, m_err);
    chk("pending_writes", wq.size(), 0);
    chk("pending_drops", dq.size(), 0);
  endtask

  // Called at a falling edge: checks state, drives one cycle, advances the model.
  task automatic step(input logic v, input logic [NUM_Q-1:0] q, input logic [DATA_W-1:0] d,
                      input logic rel, input int rq);
    int pre[NUM_Q];
    int k;
    check_state();
    dout_valid   = v;
    oq           = q;
    dout         = d;
    rd_release   = rel;
    rd_release_q = QID_W'(rq);
    pre = m_cnt;
    m_oe = 1'b1;
    for (int i = 0; i < NUM_Q; i++) if (DEPTH - pre[i] <= OE_SLACK) m_oe = 1'b0;
    if (v) begin
      if ($countones(q) != 1) begin
        m_err = 1'b1;
        dq.push_back(1'b1);
      end else begin
        k = 0;
        for (int i = 0; i < NUM_Q; i++) if (q[i]) k = i;
        if (pre[k] < DEPTH) begin
          wq.push_back('{addr: (QID_W+Q_ADDR_W)'(k * DEPTH + m_wp[k]), data: d});
          m_wp[k] = (m_wp[k] + 1) % DEPTH;
          m_cnt[k]++;
        end else begin
          dq.push_back(m_err);
        end
      end
    end
    if (rel && rq < NUM_Q && pre[rq] > 0) m_cnt[rq]--;
    @(negedge memclk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 0);
  endtask

  task automatic do_reset(input int cycles);
    memreset   = 1'b1;
    dout_valid = 1'b0;
    oq         = '0;
    dout       = '0;
    rd_release = 1'b0;
    rd_release_q = '0;
    #1;
    chk("rst_wr_en", sram_wr_en, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_oe", output_enable, 0);
    wq.delete();
    dq.delete();
    model_reset();
    repeat (cycles) begin
      @(negedge memclk);
      chk("rst_wr_addr", sram_wr_addr, 0);
      chk("rst_wr_data", sram_wr_data, 0);
      chk("rst_err_oq", err_oq, 0);
      chk("rst_q_full", q_full, 0);
    end
    memreset = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT writes or drops.
  initial begin
    wr_t  e;
    logic de;
    forever begin
      @(posedge memclk);
      #1;
      if (sram_wr_en) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_addr=%0h required=no_write", sram_wr_addr);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", sram_wr_addr, e.addr);
          chk("wr_data", sram_wr_data, e.data);
        end
      end
      if (drop_pulse) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drop actual=1 required=0");
        end else begin
          de = dq.pop_front();
          chk("drop_err_oq", err_oq, de);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_Q-1:0] rq_oq;
    do_reset(5);
    idle();
    idle();

    step(1'b1, 5'b00100, DATA_W'(50), 1'b0, 0);
    idle();

    for (int i = 0; i < 7; i++) step(1'b1, 5'b00010, rand_word(), 1'b0, 0);
    step(1'b1, 5'b00010, rand_word(), 1'b1, 1);
    idle();

    step(1'b1, 5'b00110, rand_word(), 1'b0, 0);
    step(1'b1, 5'b00000, rand_word(), 1'b0, 0);
    idle();
    idle();

    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 5'b00001, rand_word(), 1'b0, 0);
    step(1'b0, '0, '0, 1'b1, 0);
    step(1'b1, 5'b00001, rand_word(), 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b1, 0);
    step(1'b0, '0, '0, 1'b1, 6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rq_oq = NUM_Q'($urandom);
      else rq_oq = NUM_Q'(1) << $urandom_range(0, NUM_Q - 1);
      step($urandom_range(0, 3) != 0, rq_oq, rand_word(), $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 7)));
    end
    idle();

    for (int i = 0; i < 5; i++) step(1'b1, 5'b10000, rand_word(), 1'b0, 0);
    do_reset(3);
    idle();
    step(1'b1, 5'b10000, rand_word(), 1'b0, 0);
    idle();
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
